// File: rtl/instr_register_pkg.sv
// Package shared by the instruction register and its execute stage.
// Holds the instruction word layout, the execute FSM state type, the
// divider step count and small helpers for sign/magnitude conversion.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;
  typedef logic signed [63:0] result_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  // Divider iterations; equals the operand width.
  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DIVIDE,
    S_OUTPUT,
    S_DONE
  } exec_state_t;

  // Unsigned magnitude of a signed operand; -2^31 maps to 2^31 exactly.
  function automatic logic [31:0] magnitude(input operand_t v);
    logic [31:0] u;
    u = v;
    return u[31] ? (~u + 32'd1) : u;
  endfunction

  // Zero-extend a 32-bit magnitude to 64 bits and negate when requested.
  function automatic result_t apply_sign(input logic [31:0] mag, input logic neg);
    logic [63:0] ext;
    ext = {32'b0, mag};
    return neg ? result_t'(~ext + 64'd1) : result_t'(ext);
  endfunction

endpackage

// File: rtl/instr_exec_unit_divider.sv
// iter_divider: signed restoring divider working on magnitudes.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start             load a/b and begin (accepted only when not busy)
//   a, b              signed dividend / divisor (b must be non-zero)
//   busy              high while iterating
//   done              high during the last iteration cycle; quotient and
//                     remainder are valid in that same cycle
//   quotient          64-bit signed quotient, truncated toward zero
//   remainder         64-bit signed remainder, sign of a
module iter_divider
  import instr_register_pkg::*;
#(
  parameter int unsigned STEPS = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     start,
  input  operand_t a,
  input  operand_t b,
  output logic     busy,
  output logic     done,
  output result_t  quotient,
  output result_t  remainder
);

  localparam int unsigned CW = $clog2(STEPS + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   dq_q, dq_d;    // dividend shifts out of the top, quotient bits enter at the bottom
  logic [31:0]   dvs_q, dvs_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic [32:0]   shifted;
  logic          take;
  logic [31:0]   trial;
  logic [31:0]   rem_step;
  logic [31:0]   dq_step;

  // One restoring step. The partial remainder stays below the divisor
  // (<= 2^31), so 32-bit subtraction is exact whenever the step is taken.
  always_comb begin
    shifted  = {rem_q, dq_q[31]};
    take     = (shifted >= {1'b0, dvs_q});
    trial    = shifted[31:0] - dvs_q;
    rem_step = take ? trial : shifted[31:0];
    dq_step  = {dq_q[30:0], take};
  end

  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (start && !busy_q) begin
      busy_d    = 1'b1;
      cnt_d     = CW'(STEPS);
      rem_d     = '0;
      dq_d      = magnitude(a);
      dvs_d     = magnitude(b);
      neg_quo_d = a[31] ^ b[31];
      neg_rem_d = a[31];
    end else if (busy_q) begin
      rem_d = rem_step;
      dq_d  = dq_step;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dq_q      <= dq_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Final values come straight off the last step so the consumer can
  // register them on the same edge that completes the iteration.
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CW'(1));
  assign quotient  = apply_sign(dq_step, neg_quo_q);
  assign remainder = apply_sign(rem_step, neg_rem_q);

endmodule

// File: rtl/instr_exec_unit.sv
// instr_exec_unit: execute stage behind the instruction register.
// On start, walks count locations from start_addr via read_pointer,
// executes each instruction_word and offers {addr, opcode, result} on a
// valid/ready port. DIV/MOD with a non-zero divisor use iter_divider.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               run launch pulse (ignored while busy)
//   start_addr, count   first location and number of locations (0..32)
//   read_pointer        address into the instruction register
//   instruction_word    combinational read data for read_pointer
//   res_valid/res_ready result handshake
//   res_addr/res_opcode/res_data  result beat contents
//   busy                high from the cycle after start through the done cycle
//   done                one-cycle pulse after the last beat is accepted
module instr_exec_unit
  import instr_register_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_addr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output address_t     res_addr,
  output opcode_t      res_opcode,
  output result_t      res_data,
  output logic         busy,
  output logic         done
);

  exec_state_t state_q, state_d;
  address_t    read_pointer_q, read_pointer_d;
  logic [5:0]  remaining_q, remaining_d;
  logic        res_valid_q, res_valid_d;
  address_t    res_addr_q, res_addr_d;
  opcode_t     res_opcode_q, res_opcode_d;
  result_t     res_data_q, res_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        is_mod_q, is_mod_d;

  operand_t    op_a, op_b;
  opcode_t     opc;
  result_t     alu_result;
  logic        needs_divider;

  logic        div_start, div_busy, div_done;
  result_t     div_quotient, div_remainder;

  assign opc  = instruction_word.opc;
  assign op_a = instruction_word.op_a;
  assign op_b = instruction_word.op_b;

  // Single-cycle results. DIV/MOD land here only with a zero divisor.
  always_comb begin
    alu_result = '0;
    case (opc)
      ZERO:    alu_result = '0;
      PASSA:   alu_result = result_t'(op_a);
      PASSB:   alu_result = result_t'(op_b);
      ADD:     alu_result = result_t'(op_a) + result_t'(op_b);
      SUB:     alu_result = result_t'(op_a) - result_t'(op_b);
      MULT:    alu_result = result_t'(op_a) * result_t'(op_b);
      default: alu_result = '0;
    endcase
  end

  assign needs_divider = ((opc == DIV) || (opc == MOD)) && (op_b != '0);

  iter_divider #(
    .STEPS(DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (div_start),
    .a         (op_a),
    .b         (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  always_comb begin
    state_d        = state_q;
    read_pointer_d = read_pointer_q;
    remaining_d    = remaining_q;
    res_valid_d    = res_valid_q;
    res_addr_d     = res_addr_q;
    res_opcode_d   = res_opcode_q;
    res_data_d     = res_data_q;
    is_mod_d       = is_mod_q;
    div_start      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          read_pointer_d = start_addr;
          remaining_d    = count;
          state_d        = (count == 6'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        res_addr_d   = read_pointer_q;
        res_opcode_d = opc;
        if (needs_divider) begin
          // Wait for the divider to be free before handing it operands.
          if (!div_busy) begin
            div_start = 1'b1;
            is_mod_d  = (opc == MOD);
            state_d   = S_DIVIDE;
          end
        end else begin
          res_data_d  = alu_result;
          res_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end
      end
      S_DIVIDE: begin
        if (div_done) begin
          res_data_d  = is_mod_q ? div_remainder : div_quotient;
          res_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          remaining_d = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = S_DONE;
          end else begin
            read_pointer_d = read_pointer_q + 5'd1;
            state_d        = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy and done are registered views of the state being entered.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      read_pointer_q <= '0;
      remaining_q    <= '0;
      res_valid_q    <= 1'b0;
      res_addr_q     <= '0;
      res_opcode_q   <= ZERO;
      res_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      is_mod_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_pointer_q <= read_pointer_d;
      remaining_q    <= remaining_d;
      res_valid_q    <= res_valid_d;
      res_addr_q     <= res_addr_d;
      res_opcode_q   <= res_opcode_d;
      res_data_q     <= res_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      is_mod_q       <= is_mod_d;
    end
  end

  assign read_pointer = read_pointer_q;
  assign res_valid    = res_valid_q;
  assign res_addr     = res_addr_q;
  assign res_opcode   = res_opcode_q;
  assign res_data     = res_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: instruction memory model, expected-beat
// scoreboard built from plain integer arithmetic, directed timing cases
// and randomized runs with random backpressure.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic         clk;
  logic         reset_n;
  logic         start;
  address_t     start_addr;
  logic [5:0]   count;
  address_t     read_pointer;
  instruction_t iw;
  logic         res_valid;
  logic         res_ready;
  address_t     res_addr;
  opcode_t      res_opcode;
  result_t      res_data;
  logic         busy;
  logic         done;

  logic [67:0]  mem [32];

  typedef struct {
    logic [4:0] addr;
    logic [3:0] opc;
    longint     data;
  } exp_beat_t;

  exp_beat_t sb[$];
  int total = 0;
  int bad   = 0;
  int beats = 0;

  instr_exec_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_addr       (start_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (iw),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_addr         (res_addr),
    .res_opcode       (res_opcode),
    .res_data         (res_data),
    .busy             (busy),
    .done             (done)
  );

  assign iw = instruction_t'(mem[read_pointer]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference semantics from the arithmetic rules, in 64-bit integers.
  function automatic longint ref_result(input logic [3:0] opc,
                                        input logic signed [31:0] a,
                                        input logic signed [31:0] b);
    longint sa, sb_;
    sa  = a;
    sb_ = b;
    case (opc)
      4'd1:    return sa;
      4'd2:    return sb_;
      4'd3:    return sa + sb_;
      4'd4:    return sa - sb_;
      4'd5:    return sa * sb_;
      4'd6:    return (sb_ == 0) ? 64'sd0 : sa / sb_;
      4'd7:    return (sb_ == 0) ? 64'sd0 : sa % sb_;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] gen_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [67:0] gen_instr();
    int unsigned r;
    logic [3:0] o;
    r = $urandom_range(0, 21);
    o = (r < 16) ? 4'(r) : ((r < 19) ? 4'd6 : 4'd7);
    return {o, gen_op(), gen_op()};
  endfunction

  // Compare process: every accepted beat against the scoreboard, and
  // output stability while a beat is stalled.
  logic        hold_q = 1'b0;
  address_t    h_addr, h_rp;
  logic [3:0]  h_opc;
  result_t     h_data;
  always @(negedge clk) begin
    exp_beat_t e;
    if (!reset_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        total++;
        if (res_valid !== 1'b1 || res_addr !== h_addr || res_opcode !== h_opc ||
            res_data !== h_data || read_pointer !== h_rp) begin
          bad++;
          $display("FAIL hold_stable: got v=%0b a=%0d o=%0d d=%0h rp=%0d want v=1 a=%0d o=%0d d=%0h rp=%0d",
                   res_valid, res_addr, res_opcode, res_data, read_pointer, h_addr, h_opc, h_data, h_rp);
        end
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got beat addr=%0d want none", res_addr);
        end else begin
          e = sb.pop_front();
          chk("beat_addr", 64'(res_addr), 64'(e.addr));
          chk("beat_opcode", 64'(res_opcode), 64'(e.opc));
          chk("beat_data", res_data, e.data);
          beats++;
        end
      end
      if (done) chk("done_with_pending", sb.size(), 0);
      hold_q = res_valid && !res_ready;
      h_addr = res_addr;
      h_opc  = res_opcode;
      h_data = res_data;
      h_rp   = read_pointer;
    end
  end

  // Called just after a posedge; returns just after edge N (start sampled).
  task automatic launch(input int sa, input int cnt);
    exp_beat_t e;
    logic [67:0] w;
    for (int i = 0; i < cnt; i++) begin
      e.addr = 5'((sa + i) % 32);
      w      = mem[e.addr];
      e.opc  = w[67:64];
      e.data = ref_result(w[67:64], w[63:32], w[31:0]);
      sb.push_back(e);
    end
    start      = 1'b1;
    start_addr = 5'(sa);
    count      = 6'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_to_done(input int mode, output int n);
    n = 0;
    while (!done && n < 5000) begin
      res_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done, 1);
    chk("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic single(input string nm, input int ad, input logic [3:0] opc,
                        input int a, input int b, input int lat, input longint data);
    int n, n2;
    mem[ad] = {opc, 32'(a), 32'(b)};
    launch(ad, 1);
    res_ready = 1'b1;
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_data"}, res_data, data);
    chk({nm, "_addr"}, 64'(res_addr), 64'(ad));
    run_to_done(0, n2);
    chk({nm, "_done_after_beat"}, n2, 1);
  endtask

  initial begin
    int n, b0;
    address_t rp0;
    result_t d0;
    reset_n    = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    res_ready  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rp", 64'(read_pointer), 0);
    chk("rst_addr", 64'(res_addr), 0);
    chk("rst_opcode", 64'(res_opcode), 0);
    chk("rst_data", res_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    chk("model_div", ref_result(4'd6, -15, 4), -3);
    chk("model_mod", ref_result(4'd7, -15, 4), -3);
    chk("model_mult", ref_result(4'd5, -15, 15), -225);
    chk("model_div_min", ref_result(4'd6, 32'sh8000_0000, -1), 64'h0000_0000_8000_0000);

    single("basic_add", 0, 4'd3, 5, 7, 1, 12);
    single("div_neg", 3, 4'd6, -15, 4, 33, -3);
    single("mod_neg", 4, 4'd7, -15, 4, 33, -3);
    single("div_zero", 9, 4'd6, 7, 0, 1, 0);
    single("mult_neg", 12, 4'd5, -15, 15, 1, -225);
    single("opc_hi", 13, 4'd11, 3, 4, 1, 0);

    // Wrap-around from location 30.
    mem[30] = gen_instr(); mem[31] = gen_instr(); mem[0] = gen_instr(); mem[1] = gen_instr();
    b0 = beats;
    launch(30, 4);
    run_to_done(0, n);
    chk("wrap_beats", beats - b0, 4);

    // Backpressure plus a stray start while busy.
    for (int i = 5; i < 8; i++) mem[i] = gen_instr();
    b0 = beats;
    launch(5, 3);
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid_seen", res_valid, 1);
    rp0 = read_pointer;
    d0  = res_data;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start      = 1'b1;
        start_addr = 5'd20;
        count      = 6'd7;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("bp_data_held", res_data, d0);
    chk("bp_rp_held", 64'(read_pointer), 64'(rp0));
    run_to_done(1, n);
    chk("bp_beats", beats - b0, 3);

    // count = 0.
    b0 = beats;
    launch(7, 0);
    chk("cnt0_done", done, 1);
    chk("cnt0_valid", res_valid, 0);
    run_to_done(0, n);
    chk("cnt0_latency", n, 0);
    chk("cnt0_beats", beats - b0, 0);

    // Reset held two cycles in the middle of a divide.
    mem[0] = {4'd6, 32'sd1000, 32'sd7};
    launch(0, 2);
    res_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_valid", res_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rp", 64'(read_pointer), 0);
    chk("midrst_addr", 64'(res_addr), 0);
    chk("midrst_opcode", 64'(res_opcode), 0);
    chk("midrst_data", res_data, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Full 32-location run, then random runs with random backpressure.
    for (int i = 0; i < 32; i++) mem[i] = gen_instr();
    b0 = beats;
    launch($urandom_range(0, 31), 32);
    run_to_done(1, n);
    chk("full_beats", beats - b0, 32);

    for (int r = 0; r < 6; r++) begin
      int sa, cnt;
      for (int i = 0; i < 32; i++) mem[i] = gen_instr();
      sa  = $urandom_range(0, 31);
      cnt = $urandom_range(1, 32);
      b0  = beats;
      launch(sa, cnt);
      run_to_done(1, n);
      chk("rand_beats", beats - b0, cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
